// File: rtl/playfield_tx_pkg.sv
// Shared types and constants for the LAN playfield link transmitter.
// Build option PLAYFIELD_TX_GARBAGE_EN appends a garbage-lines byte to each frame.
package playfield_tx_pkg;

    localparam int PLAYFIELD_ROWS = 20;
    localparam int PLAYFIELD_COLS = 10;
    localparam logic [7:0] PF_HEADER_BYTE = 8'hA5;

`ifdef PLAYFIELD_TX_GARBAGE_EN
    localparam int GARBAGE_BYTES = 1;
`else
    localparam int GARBAGE_BYTES = 0;
`endif

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        TILE_BLANK   = 4'h0,
        TILE_GHOST   = 4'h1,
        TILE_GARBAGE = 4'h2,
        TILE_I       = 4'h3,
        TILE_O       = 4'h4,
        TILE_T       = 4'h5,
        TILE_S       = 4'h6,
        TILE_L       = 4'h7,
        TILE_J       = 4'h8,
        TILE_Z       = 4'h9
    } tile_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
`ifdef PLAYFIELD_TX_GARBAGE_EN
        ST_GARBAGE,
`endif
        ST_CHECKSUM
    } tx_state_t;

    // Header + two tiles per payload byte + optional garbage byte + checksum.
    function automatic int frame_len(input int rows, input int cols);
        return 2 + (rows * cols) / 2 + GARBAGE_BYTES;
    endfunction

    localparam int FRAME_LEN = frame_len(PLAYFIELD_ROWS, PLAYFIELD_COLS);

endpackage

// File: rtl/playfield_tx_if.sv
// Byte stream valid/ready link from the playfield transmitter to the MAC shim.
// master drives data/valid, slave returns ready.
interface playfield_tx_if;
    import playfield_tx_pkg::*;

    byte_t tx_data;
    logic  tx_valid;
    logic  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/playfield_tx_csum.sv
// Running XOR checksum over a byte stream; reusable by the receive side.
// nxt is the value the sum will take if the current byte is accumulated.
module playfield_tx_csum
    import playfield_tx_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  byte_t din,
    output byte_t sum,
    output byte_t nxt
);

    assign nxt = sum ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= nxt;
        end
    end

endmodule

// File: rtl/playfield_tx.sv
// Snapshots the local playfield and streams it as header, tile-pair payload, XOR checksum.
// Build option PLAYFIELD_TX_GARBAGE_EN adds garbage_lines as an extra checksummed byte.
module playfield_tx
    import playfield_tx_pkg::*;
#(
    parameter int          ROWS        = PLAYFIELD_ROWS,
    parameter int          COLS        = PLAYFIELD_COLS,
    parameter logic [7:0]  HEADER_BYTE = PF_HEADER_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROWS*COLS*4-1:0] tiles,
`ifdef PLAYFIELD_TX_GARBAGE_EN
    input  logic [4:0]             garbage_lines,
`endif
    playfield_tx_if.master         tx,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int NPAY = (ROWS * COLS) / 2;
    localparam int KW   = (NPAY > 1) ? $clog2(NPAY) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NPAY - 1);

    tx_state_t              state;
    logic [ROWS*COLS*4-1:0] snap;
    logic [KW-1:0]          k;
    logic                   pending;
    byte_t                  sum;
    byte_t                  nxt;
    logic                   xfer;
    logic                   launch;
    logic                   relaunch;
    logic                   cs_en;
`ifdef PLAYFIELD_TX_GARBAGE_EN
    logic [4:0]             gsnap;
`endif

    assign xfer     = tx.tx_valid && tx.tx_ready;
    assign launch   = start && (state == ST_IDLE);
    assign relaunch = xfer && (state == ST_CHECKSUM) && (pending || start);
`ifdef PLAYFIELD_TX_GARBAGE_EN
    assign cs_en    = xfer && ((state == ST_PAYLOAD) || (state == ST_GARBAGE));
`else
    assign cs_en    = xfer && (state == ST_PAYLOAD);
`endif
    assign busy     = (state != ST_IDLE) || pending;

    playfield_tx_csum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (launch || relaunch),
        .en  (cs_en),
        .din (tx.tx_data),
        .sum (sum),
        .nxt (nxt)
    );

    // Payload leaves the low end of the snapshot, so each byte is {tile 2k+1, tile 2k}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            snap        <= '0;
            k           <= '0;
            pending     <= 1'b0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            frame_done  <= 1'b0;
`ifdef PLAYFIELD_TX_GARBAGE_EN
            gsnap       <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (start && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap        <= tiles;
`ifdef PLAYFIELD_TX_GARBAGE_EN
                        gsnap       <= garbage_lines;
`endif
                        tx.tx_data  <= HEADER_BYTE;
                        tx.tx_valid <= 1'b1;
                        state       <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer) begin
                        tx.tx_data <= snap[7:0];
                        snap       <= snap >> 8;
                        k          <= '0;
                        state      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        if (k == KLAST) begin
`ifdef PLAYFIELD_TX_GARBAGE_EN
                            tx.tx_data <= {3'b000, gsnap};
                            state      <= ST_GARBAGE;
`else
                            tx.tx_data <= nxt;
                            state      <= ST_CHECKSUM;
`endif
                        end else begin
                            k          <= k + 1'b1;
                            tx.tx_data <= snap[7:0];
                            snap       <= snap >> 8;
                        end
                    end
                end
`ifdef PLAYFIELD_TX_GARBAGE_EN
                ST_GARBAGE: begin
                    if (xfer) begin
                        tx.tx_data <= nxt;
                        state      <= ST_CHECKSUM;
                    end
                end
`endif
                ST_CHECKSUM: begin
                    if (xfer) begin
                        frame_done <= 1'b1;
                        // A start landing on the final transfer is queued, not lost.
                        if (pending || start) begin
                            pending    <= 1'b0;
                            snap       <= tiles;
`ifdef PLAYFIELD_TX_GARBAGE_EN
                            gsnap      <= garbage_lines;
`endif
                            tx.tx_data <= HEADER_BYTE;
                            state      <= ST_HEADER;
                        end else begin
                            tx.tx_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playfield_tx.sv
// Self-checking bench for playfield_tx: vector table plus corner-case sequences.
// Expected bytes are queued at launch and popped as the DUT transfers them.
module tb_playfield_tx;
    import playfield_tx_pkg::*;

    localparam int W  = PLAYFIELD_ROWS * PLAYFIELD_COLS * 4;
    localparam int NP = PLAYFIELD_ROWS * PLAYFIELD_COLS / 2;
    localparam logic [7:0] G = 8'h07;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] tiles;
    logic         busy;
    logic         frame_done;
`ifdef PLAYFIELD_TX_GARBAGE_EN
    logic [4:0]   garbage_lines;
`endif

    playfield_tx_if txi();

    playfield_tx dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tiles         (tiles),
`ifdef PLAYFIELD_TX_GARBAGE_EN
        .garbage_lines (garbage_lines),
`endif
        .tx            (txi),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        byte_t data;
        bit    last;
    } exp_t;

    typedef struct {
        string        name;
        logic [W-1:0] t;
        bit           rnd;
        bit           fix;
        byte_t        ck;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[4];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    pops   = 0;
    int    frames = 0;
    bit    rnd_mode = 1'b0;
    bit    done_pend = 1'b0;
    bit    hold = 1'b0;
    byte_t hold_data = '0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] t, input bit fix,
                                       input byte_t ck_fixed);
        byte_t cs;
        byte_t b;
        byte_t ckf;
        cs  = '0;
        ckf = ck_fixed;
        sb.push_back('{data: PF_HEADER_BYTE, last: 1'b0});
        for (int k = 0; k < NP; k++) begin
            b  = t[8*k +: 8];
            cs = cs ^ b;
            sb.push_back('{data: b, last: 1'b0});
        end
`ifdef PLAYFIELD_TX_GARBAGE_EN
        cs  = cs ^ G;
        ckf = ckf ^ G;
        sb.push_back('{data: G, last: 1'b0});
`endif
        sb.push_back('{data: (fix ? ckf : cs), last: 1'b1});
    endfunction

    function automatic logic [W-1:0] ramp();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 4; i++) r[4*i +: 4] = 4'(i % 16);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_tiles();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Downstream ready: always 1 or a coin flip per cycle.
    initial begin
        txi.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            txi.tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on each transfer, hold stability, frame_done timing.
    always @(negedge clk) begin
        if (rst) begin
            done_pend = 1'b0;
            hold      = 1'b0;
        end else begin
            if (done_pend || frame_done)
                check(frame_done == done_pend, "frame_done",
                      32'(frame_done), 32'(done_pend));
            if (frame_done) frames++;
            done_pend = 1'b0;
            if (hold)
                check(txi.tx_valid && (txi.tx_data == hold_data), "hold_stable",
                      32'({txi.tx_valid, txi.tx_data}), 32'({1'b1, hold_data}));
            hold      = txi.tx_valid && !txi.tx_ready;
            hold_data = txi.tx_data;
            if (txi.tx_valid && txi.tx_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_byte", 32'(txi.tx_data), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    pops++;
                    check(txi.tx_data == e.data, "byte", 32'(txi.tx_data), 32'(e.data));
                    done_pend = e.last;
                end
            end
        end
    end

    task automatic launch(input logic [W-1:0] t);
        tiles = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(n < budget, {name, "_timeout"}, 32'(n), 32'(budget));
        @(negedge clk);
        #1;
        check(busy == 1'b0, {name, "_busy_after"}, 32'(busy), 32'(0));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int f0;
        int p0;
        int n;

        rst   = 1'b1;
        start = 1'b0;
        tiles = '0;
`ifdef PLAYFIELD_TX_GARBAGE_EN
        garbage_lines = G[4:0];
`endif

        a = '0;
        a[3:0] = 4'h3;
        a[7:4] = 4'h4;
        vecs[0] = '{name: "blank", t: '0,         rnd: 1'b0, fix: 1'b1, ck: 8'h00};
        vecs[1] = '{name: "i_o",   t: a,          rnd: 1'b0, fix: 1'b1, ck: 8'h43};
        vecs[2] = '{name: "ramp",  t: ramp(),     rnd: 1'b1, fix: 1'b1, ck: 8'h00};
        vecs[3] = '{name: "rand",  t: rand_tiles(), rnd: 1'b1, fix: 1'b0, ck: 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check(txi.tx_valid == 1'b0, "rst_valid", 32'(txi.tx_valid), 32'(0));
        check(txi.tx_data == 8'h00, "rst_data", 32'(txi.tx_data), 32'(0));
        check(busy == 1'b0, "rst_busy", 32'(busy), 32'(0));
        check(frame_done == 1'b0, "rst_done", 32'(frame_done), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            rnd_mode = vecs[i].rnd;
            f0 = frames;
            push_frame(vecs[i].t, vecs[i].fix, vecs[i].ck);
            launch(vecs[i].t);
            check(txi.tx_valid == 1'b1, {vecs[i].name, "_valid_lat"},
                  32'(txi.tx_valid), 32'(1));
            wait_idle(4000, vecs[i].name);
            check(frames - f0 == 1, {vecs[i].name, "_frames"}, 32'(frames - f0), 32'(1));
        end

        // Snapshot isolation: tiles change one cycle after start.
        rnd_mode = 1'b1;
        a = ramp();
        push_frame(a, 1'b0, 8'h00);
        launch(a);
        tiles = {(W/4){4'h9}};
        wait_idle(4000, "isolation");

        // Three starts during one frame: exactly two frames, back-to-back.
        f0 = frames;
        a  = rand_tiles();
        b  = rand_tiles();
        push_frame(a, 1'b0, 8'h00);
        push_frame(b, 1'b0, 8'h00);
        launch(a);
        tiles = b;
        for (int j = 0; j < 3; j++) begin
            repeat (20) @(posedge clk);
            #1;
            pulse_start();
        end
        n = 0;
        while (!frame_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(n < 2000, "b2b_done_wait", 32'(n), 32'(2000));
        check(txi.tx_valid && txi.tx_data == PF_HEADER_BYTE, "b2b_no_gap",
              32'({txi.tx_valid, txi.tx_data}), 32'({1'b1, PF_HEADER_BYTE}));
        wait_idle(4000, "b2b");
        check(frames - f0 == 2, "b2b_frames", 32'(frames - f0), 32'(2));

        // Start coinciding with the checksum transfer is honoured.
        rnd_mode = 1'b0;
        f0 = frames;
        a  = rand_tiles();
        push_frame(a, 1'b0, 8'h00);
        launch(a);
        n = 0;
        while (!(sb.size() == 1 && txi.tx_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(n < 500, "coinc_wait", 32'(n), 32'(500));
        b = ramp();
        push_frame(b, 1'b0, 8'h00);
        tiles = b;
        pulse_start();
        wait_idle(2000, "coinc");
        check(frames - f0 == 2, "coinc_frames", 32'(frames - f0), 32'(2));

        // Reset mid-frame, then a clean frame.
        p0 = pops;
        a  = rand_tiles();
        push_frame(a, 1'b0, 8'h00);
        launch(a);
        n = 0;
        while (pops - p0 < 51 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(n < 500, "mid_wait", 32'(n), 32'(500));
        rst = 1'b1;
        #1;
        check(txi.tx_valid == 1'b0, "mid_rst_valid", 32'(txi.tx_valid), 32'(0));
        check(txi.tx_data == 8'h00, "mid_rst_data", 32'(txi.tx_data), 32'(0));
        check(busy == 1'b0, "mid_rst_busy", 32'(busy), 32'(0));
        check(frame_done == 1'b0, "mid_rst_done", 32'(frame_done), 32'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        f0 = frames;
        p0 = pops;
        a  = rand_tiles();
        push_frame(a, 1'b0, 8'h00);
        launch(a);
        wait_idle(2000, "post_rst");
        check(frames - f0 == 1, "post_rst_frames", 32'(frames - f0), 32'(1));
        check(pops - p0 == FRAME_LEN, "post_rst_len", 32'(pops - p0), 32'(FRAME_LEN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
